// File: rtl/bp_ras_predecode_pkg.sv
// Shared types and helpers for the fetch pre-decode / RAS predictor slice.
// - ctrl_type_t: control-transfer class of one RV32I instruction
// - OP_*: major opcodes of the control-transfer instructions
// - is_link(): x1/x5 are the link registers used for call/return hints
// - ADDR_WIDTH macro defaults to 32 when the build does not supply it
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package bp_predecode_pkg;
  localparam int FETCH_W = 2;
  localparam int ADDR_W  = `ADDR_WIDTH;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    NONE, BRANCH, JAL, JALR, CALL, RET, CALL_RET
  } ctrl_type_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction
endpackage

// File: rtl/bp_ras_predecode_if.sv
// Channels around the pre-decode stage.
// bp_fetch_if : fetch bundle in (valid/pc/inst), accept + next-PC prediction out.
//   master = fetch unit, slave = pre-decode stage.
// bp_decode_if: registered bundle toward decode with valid/ready.
//   master = pre-decode stage, slave = decode.
interface bp_fetch_if #(
  parameter int FETCH_WIDTH = bp_predecode_pkg::FETCH_W,
  parameter int ADDR_WIDTH  = bp_predecode_pkg::ADDR_W
);
  logic                              fetch_bp_valid;
  logic [ADDR_WIDTH-1:0]             fetch_bp_pc;
  logic [FETCH_WIDTH-1:0][31:0]      fetch_bp_inst;
  logic                              bp_fetch_ready;
  logic [ADDR_WIDTH-1:0]             bp_fetch_next_pc;
  logic                              bp_fetch_redirect;

  modport master (output fetch_bp_valid, fetch_bp_pc, fetch_bp_inst,
                  input  bp_fetch_ready, bp_fetch_next_pc, bp_fetch_redirect);
  modport slave  (input  fetch_bp_valid, fetch_bp_pc, fetch_bp_inst,
                  output bp_fetch_ready, bp_fetch_next_pc, bp_fetch_redirect);
endinterface

interface bp_decode_if #(
  parameter int FETCH_WIDTH = bp_predecode_pkg::FETCH_W,
  parameter int ADDR_WIDTH  = bp_predecode_pkg::ADDR_W
);
  logic                              bp_decode_valid;
  logic                              bp_decode_ready;
  logic [ADDR_WIDTH-1:0]             bp_decode_pc;
  logic [FETCH_WIDTH-1:0][31:0]      bp_decode_inst;
  logic [FETCH_WIDTH-1:0]            bp_decode_inst_valid;
  logic                              bp_decode_jump;
  logic [ADDR_WIDTH-1:0]             bp_decode_target;

  modport master (output bp_decode_valid, bp_decode_pc, bp_decode_inst,
                         bp_decode_inst_valid, bp_decode_jump, bp_decode_target,
                  input  bp_decode_ready);
  modport slave  (input  bp_decode_valid, bp_decode_pc, bp_decode_inst,
                         bp_decode_inst_valid, bp_decode_jump, bp_decode_target,
                  output bp_decode_ready);
endinterface

// File: rtl/bp_ras_predecode_classify.sv
// bp_inst_classify: combinational per-slot pre-decoder.
// Ports: inst (raw RV32I), pc (slot PC) -> ctype (control class),
//        taken (statically predicted taken), target (pc+imm, J or B form),
//        link_addr (pc+4, wraps modulo 2^ADDR_WIDTH).
// RET/CALL_RET targets come from the RAS and are selected by the caller.
module bp_inst_classify
  import bp_predecode_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic [31:0]           inst,
  input  logic [ADDR_WIDTH-1:0] pc,
  output ctrl_type_t            ctype,
  output logic                  taken,
  output logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] link_addr
);
  logic [6:0]            opc;
  logic [4:0]            rd, rs1;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] imm_j, imm_b;

  assign opc    = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign funct3 = inst[14:12];
  assign imm_j  = {{(ADDR_WIDTH-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_b  = {{(ADDR_WIDTH-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign link_addr = pc + ADDR_WIDTH'(4);

  always_comb begin
    ctype  = NONE;
    taken  = 1'b0;
    target = pc + imm_j;
    unique case (opc)
      OP_JAL: begin
        ctype = is_link(rd) ? CALL : JAL;
        taken = 1'b1;
      end
      OP_JALR: if (funct3 == 3'b000) begin
        // Only returns use the RAS top as a target; register-indirect
        // calls/jumps have no target source here and fall through.
        if (is_link(rd) && is_link(rs1) && rd != rs1) begin
          ctype = CALL_RET;
          taken = 1'b1;
        end else if (is_link(rd)) begin
          ctype = CALL;
        end else if (rd == 5'd0 && is_link(rs1)) begin
          ctype = RET;
          taken = 1'b1;
        end else begin
          ctype = JALR;
        end
      end
      OP_BRANCH: begin
        ctype  = BRANCH;
        taken  = inst[31];   // backward taken, forward not taken
        target = pc + imm_b;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/bp_ras_predecode.sv
// bp_ras_predecode: fetch-to-decode pre-decode stage with RAS-based return
// prediction and a single registered output slot.
// Ports: clk, rst (sync, active-low); fetch (bp_fetch_if.slave) bundle in +
//        next-PC prediction out; dcd (bp_decode_if.master) registered bundle;
//        bp_ras_addr/push/pop RAS request; ras_bp_addr RAS top (pre-update);
//        commit_bp_flush; bp_csrf_call_add/ret_add perf pulses.
// Optional feature macro: BP_RAS_PREDECODE_PERF_EN (registered perf pulses;
// when undefined the perf ports are tied low).
module bp_ras_predecode
  import bp_predecode_pkg::*;
#(
  parameter int FETCH_WIDTH = FETCH_W,
  parameter int ADDR_WIDTH  = ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  bp_fetch_if.slave             fetch,
  bp_decode_if.master           dcd,
  output logic [ADDR_WIDTH-1:0] bp_ras_addr,
  output logic                  bp_ras_push,
  output logic                  bp_ras_pop,
  input  logic [ADDR_WIDTH-1:0] ras_bp_addr,
  input  logic                  commit_bp_flush,
  output logic                  bp_csrf_call_add,
  output logic                  bp_csrf_ret_add
);
  ctrl_type_t                               ctype [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0]                   taken;
  logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0]   tgt, link;

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
    logic [ADDR_WIDTH-1:0] slot_pc;
    assign slot_pc = fetch.fetch_bp_pc + ADDR_WIDTH'(4 * i);
    bp_inst_classify #(.ADDR_WIDTH(ADDR_WIDTH)) u_cls (
      .inst(fetch.fetch_bp_inst[i]), .pc(slot_pc), .ctype(ctype[i]),
      .taken(taken[i]), .target(tgt[i]), .link_addr(link[i]));
  end

  // First taken transfer wins; slots behind it are killed. The RAS op comes
  // from the first call/return among surviving slots, so an untaken
  // jalr-call still pushes while a later taken transfer can redirect.
  logic                   hit, op_found, op_push, op_pop;
  logic [ADDR_WIDTH-1:0]  hit_tgt, op_addr, next_pc;
  logic [FETCH_WIDTH-1:0] ivld;

  always_comb begin
    hit      = 1'b0;
    hit_tgt  = '0;
    ivld     = '1;
    op_found = 1'b0;
    op_push  = 1'b0;
    op_pop   = 1'b0;
    op_addr  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (hit) begin
        ivld[i] = 1'b0;
      end else begin
        if (!op_found && ctype[i] inside {CALL, RET, CALL_RET}) begin
          op_found = 1'b1;
          op_push  = ctype[i] inside {CALL, CALL_RET};
          op_pop   = ctype[i] inside {RET, CALL_RET};
          op_addr  = link[i];
        end
        if (taken[i]) begin
          hit     = 1'b1;
          hit_tgt = (ctype[i] inside {RET, CALL_RET}) ? ras_bp_addr : tgt[i];
        end
      end
    end
  end

  logic vld_q, accept;
  assign next_pc = hit ? hit_tgt : fetch.fetch_bp_pc + ADDR_WIDTH'(4 * FETCH_WIDTH);
  assign fetch.bp_fetch_ready    = !commit_bp_flush && (!vld_q || dcd.bp_decode_ready);
  assign accept                  = fetch.fetch_bp_valid && fetch.bp_fetch_ready && rst;
  assign fetch.bp_fetch_next_pc  = next_pc;
  assign fetch.bp_fetch_redirect = accept && hit;
  assign bp_ras_push             = accept && op_push;
  assign bp_ras_pop              = accept && op_pop;
  assign bp_ras_addr             = op_addr;

  logic [ADDR_WIDTH-1:0]        pc_q, tgt_q;
  logic [FETCH_WIDTH-1:0][31:0] inst_q;
  logic [FETCH_WIDTH-1:0]       iv_q;
  logic                         jump_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
      iv_q   <= '0;
      jump_q <= 1'b0;
      tgt_q  <= '0;
    end else if (commit_bp_flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      pc_q   <= fetch.fetch_bp_pc;
      inst_q <= fetch.fetch_bp_inst;
      iv_q   <= ivld;
      jump_q <= hit;
      tgt_q  <= next_pc;
    end else if (dcd.bp_decode_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign dcd.bp_decode_valid      = vld_q;
  assign dcd.bp_decode_pc         = pc_q;
  assign dcd.bp_decode_inst       = inst_q;
  assign dcd.bp_decode_inst_valid = iv_q;
  assign dcd.bp_decode_jump       = jump_q;
  assign dcd.bp_decode_target     = tgt_q;

`ifdef BP_RAS_PREDECODE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      bp_csrf_call_add <= 1'b0;
      bp_csrf_ret_add  <= 1'b0;
    end else begin
      bp_csrf_call_add <= bp_ras_push;
      bp_csrf_ret_add  <= bp_ras_pop;
    end
  end
`else
  assign bp_csrf_call_add = 1'b0;
  assign bp_csrf_ret_add  = 1'b0;
`endif
endmodule

// File: tb/tb_bp_ras_predecode.sv
module tb_bp_ras_predecode;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ras_bp_addr = '0;
  logic        commit_bp_flush = 1'b0;
  logic [31:0] bp_ras_addr;
  logic        bp_ras_push, bp_ras_pop, call_add, ret_add;

  bp_fetch_if  fif();
  bp_decode_if dif();

  bp_ras_predecode dut (
    .clk(clk), .rst(rst), .fetch(fif), .dcd(dif),
    .bp_ras_addr(bp_ras_addr), .bp_ras_push(bp_ras_push), .bp_ras_pop(bp_ras_pop),
    .ras_bp_addr(ras_bp_addr), .commit_bp_flush(commit_bp_flush),
    .bp_csrf_call_add(call_add), .bp_csrf_ret_add(ret_add));

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h00000013;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_perf(input logic p, input logic q);
`ifdef BP_RAS_PREDECODE_PERF_EN
    chk("perf_call", call_add, p);
    chk("perf_ret", ret_add, q);
`else
    chk("perf_call", call_add, 1'b0 & p);
    chk("perf_ret", ret_add, 1'b0 & q);
`endif
  endtask

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input int imm);
    logic [31:0] m;
    m = imm;
    return {m[20], m[10:1], m[11], m[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, 7'b1100111};
  endfunction
  function automatic logic [31:0] enc_beq(input int imm);
    logic [31:0] m;
    m = imm;
    return {m[12], m[10:5], 5'd0, 5'd0, 3'b000, m[4:1], m[11], 7'b1100011};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [31:0] ras);
    fif.fetch_bp_valid = v;
    fif.fetch_bp_pc    = pc;
    fif.fetch_bp_inst  = {i1, i0};
    ras_bp_addr        = ras;
  endtask

  typedef struct {
    logic [31:0] pc, i0, i1, ras, nxt;
    logic        redir, push, pop;
    logic [31:0] raddr;
    logic [1:0]  iv;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] inst;
    logic [1:0]  iv;
    logic        jump;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];

  // Decode-side scoreboard: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && dif.bp_decode_valid && dif.bp_decode_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dec_pc", dif.bp_decode_pc, e.pc);
        chk("dec_inst", dif.bp_decode_inst, e.inst);
        chk("dec_iv", dif.bp_decode_inst_valid, e.iv);
        chk("dec_jump", dif.bp_decode_jump, e.jump);
        chk("dec_target", dif.bp_decode_target, e.tgt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[11];
    logic prev_push, prev_pop;
    vt[0]  = '{32'h1000, enc_jal(1, 'h100), NOP, 32'h0, 32'h1100, 1, 1, 0, 32'h1004, 2'b01};
    vt[1]  = '{32'h2000, NOP, enc_jalr(0, 1), 32'h1004, 32'h1004, 1, 0, 1, 32'h0, 2'b11};
    vt[2]  = '{32'h3000, enc_beq(-8), NOP, 32'h0, 32'h2ff8, 1, 0, 0, 32'h0, 2'b01};
    vt[3]  = '{32'h3000, enc_beq(8), NOP, 32'h0, 32'h3008, 0, 0, 0, 32'h0, 2'b11};
    vt[4]  = '{32'hFFFFFFFC, enc_jalr(1, 5), NOP, 32'h5555, 32'h5555, 1, 1, 1, 32'h0, 2'b01};
    vt[5]  = '{32'h4000, enc_jal(0, 'h20), enc_jal(1, 'h40), 32'h0, 32'h4020, 1, 0, 0, 32'h0, 2'b01};
    vt[6]  = '{32'h5000, enc_jalr(1, 6), NOP, 32'h0, 32'h5008, 0, 1, 0, 32'h5004, 2'b11};
    vt[7]  = '{32'h6000, NOP, NOP, 32'h0, 32'h6008, 0, 0, 0, 32'h0, 2'b11};
    vt[8]  = '{32'h7000, NOP, enc_jal(5, -'h10), 32'h0, 32'h6ff4, 1, 1, 0, 32'h7008, 2'b11};
    vt[9]  = '{32'h8000, enc_jalr(0, 7), enc_beq(-4), 32'h0, 32'h8000, 1, 0, 0, 32'h0, 2'b11};
    vt[10] = '{32'hFFFFFFF8, NOP, enc_jal(0, 8), 32'h0, 32'h00000004, 1, 0, 0, 32'h0, 2'b11};

    // Reset: a call presented during reset must not reach the RAS or the slot.
    dif.bp_decode_ready = 1'b1;
    drive(1, 32'h1000, enc_jal(1, 'h100), NOP, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_push", bp_ras_push, 0);
    chk("rst_pop", bp_ras_pop, 0);
    chk("rst_redirect", fif.bp_fetch_redirect, 0);
    chk("rst_dec_valid", dif.bp_decode_valid, 0);
    chk("rst_dec_pc", dif.bp_decode_pc, 0);
    chk("rst_dec_iv", dif.bp_decode_inst_valid, 0);
    chk_perf(0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 32'h0, NOP, NOP, 32'h0);

    // Table: back-to-back accepts with decode always ready.
    prev_push = 1'b0;
    prev_pop  = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
      drive(1, vt[k].pc, vt[k].i0, vt[k].i1, vt[k].ras);
      @(negedge clk);
      chk("fetch_ready", fif.bp_fetch_ready, 1);
      chk("next_pc", fif.bp_fetch_next_pc, vt[k].nxt);
      chk("redirect", fif.bp_fetch_redirect, vt[k].redir);
      chk("ras_push", bp_ras_push, vt[k].push);
      chk("ras_pop", bp_ras_pop, vt[k].pop);
      if (vt[k].push) chk("ras_addr", bp_ras_addr, vt[k].raddr);
      chk_perf(prev_push, prev_pop);
      sb.push_back('{vt[k].pc, {vt[k].i1, vt[k].i0}, vt[k].iv, vt[k].redir, vt[k].nxt});
      prev_push = vt[k].push;
      prev_pop  = vt[k].pop;
    end
    @(posedge clk); #1;
    drive(0, 32'h0, NOP, NOP, 32'h0);
    @(negedge clk);
    chk_perf(prev_push, prev_pop);
    @(posedge clk); #1;
    chk("sb_drain_table", sb.size(), 0);

    // Backpressure: full slot stalls a pending call; exactly one push on release.
    dif.bp_decode_ready = 1'b0;
    drive(1, 32'h9000, NOP, NOP, 32'h0);
    @(negedge clk);
    chk("bp_ready_empty", fif.bp_fetch_ready, 1);
    sb.push_back('{32'h9000, {NOP, NOP}, 2'b11, 1'b0, 32'h9008});
    @(posedge clk); #1;
    drive(1, 32'hA000, enc_jal(1, 'h40), NOP, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready_stall", fif.bp_fetch_ready, 0);
      chk("bp_push_stall", bp_ras_push, 0);
      chk("bp_slot_hold", dif.bp_decode_pc, 32'h9000);
      @(posedge clk); #1;
    end
    dif.bp_decode_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_release", fif.bp_fetch_ready, 1);
    chk("bp_push_release", bp_ras_push, 1);
    chk("bp_ras_addr", bp_ras_addr, 32'hA004);
    chk("bp_next_pc", fif.bp_fetch_next_pc, 32'hA040);
    sb.push_back('{32'hA000, {NOP, enc_jal(1, 'h40)}, 2'b01, 1'b1, 32'hA040});
    @(posedge clk); #1;
    drive(0, 32'h0, NOP, NOP, 32'h0);
    @(negedge clk);
    chk("bp_push_once", bp_ras_push, 0);
    chk_perf(1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_perf(0, 0);
    chk("sb_drain_bp", sb.size(), 0);

    // Flush beats a simultaneous return: no pop, slot dropped next cycle.
    @(posedge clk); #1;
    dif.bp_decode_ready = 1'b0;
    drive(1, 32'hB000, NOP, NOP, 32'h0);
    @(negedge clk);
    sb.push_back('{32'hB000, {NOP, NOP}, 2'b11, 1'b0, 32'hB008});
    @(posedge clk); #1;
    drive(1, 32'hB100, enc_jalr(0, 5), NOP, 32'h1234);
    commit_bp_flush = 1'b1;
    @(negedge clk);
    chk("fl_pop", bp_ras_pop, 0);
    chk("fl_ready", fif.bp_fetch_ready, 0);
    chk("fl_redirect", fif.bp_fetch_redirect, 0);
    chk("fl_valid_before", dif.bp_decode_valid, 1);
    @(posedge clk); #1;
    commit_bp_flush = 1'b0;
    drive(0, 32'h0, NOP, NOP, 32'h0);
    @(negedge clk);
    chk("fl_valid_after", dif.bp_decode_valid, 0);
    sb.delete();

    // Reset mid-operation: slot dropped, no push while reset is asserted.
    @(posedge clk); #1;
    drive(1, 32'hC000, NOP, NOP, 32'h0);
    @(negedge clk);
    sb.push_back('{32'hC000, {NOP, NOP}, 2'b11, 1'b0, 32'hC008});
    @(posedge clk); #1;
    rst = 1'b0;
    dif.bp_decode_ready = 1'b1;
    drive(1, 32'hD000, enc_jal(1, 'h80), NOP, 32'h0);
    @(negedge clk);
    chk("mr_push", bp_ras_push, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 32'h0, NOP, NOP, 32'h0);
    @(negedge clk);
    chk("mr_valid", dif.bp_decode_valid, 0);
    chk("mr_pc", dif.bp_decode_pc, 0);
    chk_perf(0, 0);
    sb.delete();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
